// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pixel width, arbiter states and framebuffer geometry
package vga_pkg;

  // RGB444 pixel, one nibble per channel
  localparam int PIX_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISP_RD = 2'd1,
    HOST_WR = 2'd2
  } arbState_t;

  // Framebuffer extent along one axis for a given screen extent and upscale shift
  function automatic int fbDim(input int extent, input int scaleSh);
    return extent >> scaleSh;
  endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// rtl/vga_wr_fifo.sv - synchronous host write FIFO with registered ready
module vga_wr_fifo #(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iPushValid,
  output logic              oPushReady,
  input  logic [DATA_W-1:0] iPushData,
  input  logic              iPop,
  output logic              oEmpty,
  output logic [DATA_W-1:0] oHeadData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    countNext;
  logic              push;
  logic              pop;

  assign push      = iPushValid && oPushReady;
  assign pop       = iPop && !oEmpty;
  assign oEmpty    = (count == '0);
  assign oHeadData = store[rdPtr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged
  always_comb begin
    countNext = count;
    if (push && !pop) begin
      countNext = count + 1'b1;
    end else if (!push && pop) begin
      countNext = count - 1'b1;
    end
  end

  // Pointers wrap naturally at DEPTH; ready is registered from the next occupancy
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      oPushReady <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count      <= countNext;
      oPushReady <= (countNext != FULL_CNT);
    end
  end

  // Entry storage needs no reset; occupancy alone defines what is valid
  always_ff @(posedge iClk) begin
    if (push) store[wrPtr] <= iPushData;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter between display scan-out and host writes
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int SCALE_SH   = 2,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [9:0]        iCountH,
  input  logic [9:0]        iCountV,
  input  logic              iWrValid,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [PIX_W-1:0]  iWrData,
  output logic              oWrReady,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemWe,
  output logic [PIX_W-1:0]  oMemWData,
  input  logic [PIX_W-1:0]  iMemRData,
  output logic [3:0]        oRed,
  output logic [3:0]        oGreen,
  output logic [3:0]        oBlue,
  output logic              oErr
);

  localparam int FB_W    = fbDim(WIDTH, SCALE_SH);
  localparam int FB_H    = fbDim(HEIGHT, SCALE_SH);
  localparam int ENTRY_W = ADDR_W + PIX_W;
  localparam logic [ADDR_W-1:0] FB_SIZE  = ADDR_W'(FB_W * FB_H);
  localparam logic [9:0]        WIDTH_C  = 10'(WIDTH);
  localparam logic [9:0]        HEIGHT_C = 10'(HEIGHT);

  arbState_t          state;
  logic               inActive;
  logic               dispSlot;
  logic [ADDR_W-1:0]  rdAddr;
  logic               fifoEmpty;
  logic               fifoPop;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  headAddr;
  logic [PIX_W-1:0]   headData;
  logic               act1;
  logic               slot1;
  logic               act2;
  logic               slot2;
  logic [PIX_W-1:0]   pixel;

  // One framebuffer read per upscaled column: the first clock of each group of 2^SCALE_SH
  assign inActive = (iCountH < WIDTH_C) && (iCountV < HEIGHT_C);
  assign dispSlot = inActive && (iCountH[SCALE_SH-1:0] == '0);
  assign rdAddr   = ADDR_W'(iCountV >> SCALE_SH) * ADDR_W'(FB_W) + ADDR_W'(iCountH >> SCALE_SH);

  // Host writes drain on every cycle the display does not own the port
  assign fifoPop  = !dispSlot && !fifoEmpty;
  assign headAddr = head[ENTRY_W-1:PIX_W];
  assign headData = head[PIX_W-1:0];

  vga_wr_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) uWrFifo (
    .iClk       (iClk),
    .iRst       (iRst),
    .iPushValid (iWrValid),
    .oPushReady (oWrReady),
    .iPushData  ({iWrAddr, iWrData}),
    .iPop       (fifoPop),
    .oEmpty     (fifoEmpty),
    .oHeadData  (head)
  );

  // Arbitrate the memory port: display reads win, otherwise issue or drop the FIFO head
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      oMemAddr  <= '0;
      oMemWData <= '0;
      oErr      <= 1'b0;
    end else begin
      oErr <= 1'b0;
      if (dispSlot) begin
        state    <= DISP_RD;
        oMemAddr <= rdAddr;
      end else if (!fifoEmpty) begin
        if (headAddr < FB_SIZE) begin
          state     <= HOST_WR;
          oMemAddr  <= headAddr;
          oMemWData <= headData;
        end else begin
          state <= IDLE;
          oErr  <= 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

  // Write enable is a pure decode of the registered state, so reset kills it at once
  assign oMemWe = (state == HOST_WR);

  // Track active/slot through the memory latency; latch read data on slots, hold within the column
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      act1  <= 1'b0;
      slot1 <= 1'b0;
      act2  <= 1'b0;
      slot2 <= 1'b0;
      pixel <= '0;
    end else begin
      act1  <= inActive;
      slot1 <= dispSlot;
      act2  <= act1;
      slot2 <= slot1;
      if (slot2) begin
        pixel <= iMemRData;
      end else if (!act2) begin
        pixel <= '0;
      end
    end
  end

  assign oRed   = pixel[11:8];
  assign oGreen = pixel[7:4];
  assign oBlue  = pixel[3:0];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 15;
  localparam int HIST   = 1024;

  logic              iClk = 1'b0;
  logic              iRst;
  logic [9:0]        iCountH;
  logic [9:0]        iCountV;
  logic              iWrValid;
  logic [ADDR_W-1:0] iWrAddr;
  logic [11:0]       iWrData;
  logic              oWrReady;
  logic [ADDR_W-1:0] oMemAddr;
  logic              oMemWe;
  logic [11:0]       oMemWData;
  logic [11:0]       iMemRData = 12'h000;
  logic [3:0]        oRed;
  logic [3:0]        oGreen;
  logic [3:0]        oBlue;
  logic              oErr;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int errCnt      = 0;

  int hostA [$];
  int hostD [$];
  int wrA   [$];
  int wrD   [$];

  logic              hWe   [HIST];
  logic [ADDR_W-1:0] hAddr [HIST];
  logic [11:0]       hRgb  [HIST];
  logic              hErr  [HIST];
  logic              hRdy  [HIST];

  logic [11:0] mem [0:32767];

  vga_fb_arbiter dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iCountH   (iCountH),
    .iCountV   (iCountV),
    .iWrValid  (iWrValid),
    .iWrAddr   (iWrAddr),
    .iWrData   (iWrData),
    .oWrReady  (oWrReady),
    .oMemAddr  (oMemAddr),
    .oMemWe    (oMemWe),
    .oMemWData (oMemWData),
    .iMemRData (iMemRData),
    .oRed      (oRed),
    .oGreen    (oGreen),
    .oBlue     (oBlue),
    .oErr      (oErr)
  );

  always #5 iClk = ~iClk;

  // Single-port synchronous framebuffer model
  always @(posedge iClk) begin
    if (oMemWe) mem[oMemAddr] <= oMemWData;
    iMemRData <= mem[oMemAddr];
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic queueWr(input int a, input int d);
    hostA.push_back(a);
    hostD.push_back(d);
  endtask

  // Drive one cycle of counts and host traffic at the falling edge, then record outputs
  task automatic tick(input int h, input int v);
    logic acc;
    iCountH = 10'(h);
    iCountV = 10'(v);
    if (hostA.size() > 0) begin
      iWrValid = 1'b1;
      iWrAddr  = ADDR_W'(hostA[0]);
      iWrData  = 12'(hostD[0]);
    end else begin
      iWrValid = 1'b0;
      iWrAddr  = '0;
      iWrData  = '0;
    end
    acc = iWrValid && oWrReady;
    @(negedge iClk);
    if (acc) begin
      void'(hostA.pop_front());
      void'(hostD.pop_front());
    end
    cyc++;
    if (cyc < HIST) begin
      hWe[cyc]   = oMemWe;
      hAddr[cyc] = oMemAddr;
      hRgb[cyc]  = {oRed, oGreen, oBlue};
      hErr[cyc]  = oErr;
      hRdy[cyc]  = oWrReady;
    end
    if (oMemWe) begin
      wrA.push_back(int'(oMemAddr));
      wrD.push_back(int'(oMemWData));
    end
    if (oErr) errCnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0;
    int first;
    int errBefore;
    int nWe;

    iRst     = 1'b1;
    iCountH  = 10'd700;
    iCountV  = 10'd490;
    iWrValid = 1'b0;
    iWrAddr  = '0;
    iWrData  = '0;
    repeat (2) @(negedge iClk);

    checkEq("rst_we",    32'(oMemWe), 32'd0);
    checkEq("rst_addr",  32'(oMemAddr), 32'd0);
    checkEq("rst_wdata", 32'(oMemWData), 32'd0);
    checkEq("rst_rgb",   32'({oRed, oGreen, oBlue}), 32'd0);
    checkEq("rst_err",   32'(oErr), 32'd0);
    checkEq("rst_rdy",   32'(oWrReady), 32'd0);

    iRst = 1'b0;
    tick(700, 490);
    checkEq("rdy_after_rst", 32'(hRdy[cyc]), 32'd1);

    // Blanking: four back-to-back writes issue on four consecutive cycles
    queueWr(320, 'hF0A);
    queueWr(321, 'h5C3);
    queueWr(322, 'h777);
    queueWr(323, 'h123);
    t0 = cyc;
    first = wrA.size();
    for (int i = 0; i < 8; i++) tick(650 + i, 490);
    checkEq("blank_nwr", 32'(wrA.size() - first), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkEq($sformatf("blank_we%0d", i), 32'(hWe[t0 + 2 + i]), 32'd1);
      checkEq($sformatf("blank_rdy%0d", i), 32'(hRdy[t0 + 1 + i]), 32'd1);
    end
    checkEq("blank_a0", 32'(wrA[first + 0]), 32'd320);
    checkEq("blank_d0", 32'(wrD[first + 0]), 32'hF0A);
    checkEq("blank_a3", 32'(wrA[first + 3]), 32'd323);
    checkEq("blank_d3", 32'(wrD[first + 3]), 32'h123);
    checkEq("blank_we_end", 32'(hWe[t0 + 6]), 32'd0);

    // Active line V=8: reads at slots, host writes in the gaps, 3-cycle pixel latency
    queueWr(1000, 'hABC);
    queueWr(1001, 'hABD);
    queueWr(1002, 'hABE);
    t0 = cyc;
    for (int h = 0; h < 12; h++) tick(h, 8);
    for (int h = 640; h < 644; h++) tick(h, 8);
    checkEq("act_rd0_addr", 32'(hAddr[t0 + 1]), 32'd320);
    checkEq("act_rd0_we",   32'(hWe[t0 + 1]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkEq($sformatf("act_wr%0d_we", i), 32'(hWe[t0 + 2 + i]), 32'd1);
      checkEq($sformatf("act_wr%0d_addr", i), 32'(hAddr[t0 + 2 + i]), 32'(1000 + i));
    end
    checkEq("act_rd1_addr", 32'(hAddr[t0 + 5]), 32'd321);
    checkEq("act_rd1_we",   32'(hWe[t0 + 5]), 32'd0);
    checkEq("act_rd2_addr", 32'(hAddr[t0 + 9]), 32'd322);
    checkEq("rgb_before",   32'(hRgb[t0 + 2]), 32'd0);
    for (int i = 0; i < 4; i++)
      checkEq($sformatf("rgb_hold%0d", i), 32'(hRgb[t0 + 3 + i]), 32'hF0A);
    checkEq("rgb_next_col", 32'(hRgb[t0 + 7]), 32'h5C3);
    checkEq("rgb_col2",     32'(hRgb[t0 + 11]), 32'h777);
    checkEq("rgb_col2_end", 32'(hRgb[t0 + 14]), 32'h777);
    checkEq("rgb_blank",    32'(hRgb[t0 + 15]), 32'd0);

    // Six writes while slots hold the port: FIFO fills, ready drops, nothing is lost
    for (int i = 0; i < 6; i++) queueWr(2000 + i, 'hA00 + i);
    t0 = cyc;
    first = wrA.size();
    for (int i = 0; i < 6; i++) tick(0, 8);
    for (int i = 0; i < 12; i++) tick(700, 490);
    checkEq("full_rdy_occ3", 32'(hRdy[t0 + 3]), 32'd1);
    checkEq("full_rdy_occ4", 32'(hRdy[t0 + 4]), 32'd0);
    nWe = 0;
    for (int i = 1; i <= 6; i++) nWe += int'(hWe[t0 + i]);
    checkEq("full_no_wr_in_slots", 32'(nWe), 32'd0);
    checkEq("full_nwr", 32'(wrA.size() - first), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkEq($sformatf("full_a%0d", i), 32'(wrA[first + i]), 32'(2000 + i));
      checkEq($sformatf("full_d%0d", i), 32'(wrD[first + i]), 32'(12'hA00 + i));
    end
    checkEq("full_host_drained", 32'(hostA.size()), 32'd0);

    // Out-of-range address is dropped with a single error pulse
    queueWr(19200, 'hFFF);
    queueWr(19199, 'h321);
    t0 = cyc;
    first = wrA.size();
    errBefore = errCnt;
    for (int i = 0; i < 6; i++) tick(700 + i, 490);
    checkEq("oor_err",      32'(hErr[t0 + 2]), 32'd1);
    checkEq("oor_we",       32'(hWe[t0 + 2]), 32'd0);
    checkEq("oor_err_end",  32'(hErr[t0 + 3]), 32'd0);
    checkEq("oor_next_we",  32'(hWe[t0 + 3]), 32'd1);
    checkEq("oor_next_a",   32'(hAddr[t0 + 3]), 32'd19199);
    checkEq("oor_err_cnt",  32'(errCnt - errBefore), 32'd1);
    checkEq("oor_nwr",      32'(wrA.size() - first), 32'd1);

    // Reset with a write in flight and entries pending
    for (int i = 0; i < 3; i++) queueWr(3000 + i, 'h100 + i);
    for (int i = 0; i < 3; i++) tick(0, 8);
    tick(700, 490);
    checkEq("rst_inflight_we", 32'(hWe[cyc]), 32'd1);
    iRst = 1'b1;
    #1;
    checkEq("rst_async_we",   32'(oMemWe), 32'd0);
    checkEq("rst_async_rdy",  32'(oWrReady), 32'd0);
    checkEq("rst_async_addr", 32'(oMemAddr), 32'd0);
    first = wrA.size();
    tick(701, 490);
    tick(702, 490);
    iRst = 1'b0;
    tick(703, 490);
    checkEq("rst_rel_rdy", 32'(hRdy[cyc]), 32'd1);
    for (int i = 0; i < 4; i++) tick(704 + i, 490);
    checkEq("rst_fifo_empty", 32'(wrA.size() - first), 32'd0);
    checkEq("rst_rdy_held",   32'(hRdy[cyc]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- SCALE_SH, 2, log2 of the upscale factor; the framebuffer is (WIDTH>>SCALE_SH) x (HEIGHT>>SCALE_SH) = 160x120.
- ADDR_W, 15, framebuffer address width.
- FIFO_DEPTH, 4, host write FIFO entries, power of 2.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- iClk  in  1  pixel clock.
- iRst  in  1  asynchronous active-high reset.
- iCountH  in  10  horizontal counter from the timing generator.
- iCountV  in  10  vertical counter from the timing generator.
- iWrValid  in  1  host write request.
- iWrAddr  in  ADDR_W  host write address.
- iWrData  in  12  host write data, RGB444.
- oWrReady  out  1  FIFO can accept a host write.
- oMemAddr  out  ADDR_W  single-port framebuffer address.
- oMemWe  out  1  framebuffer write enable.
- oMemWData  out  12  framebuffer write data.
- iMemRData  in  12  framebuffer read data, one cycle after oMemAddr.
- oRed  out  4  display red.
- oGreen  out  4  display green.
- oBlue  out  4  display blue.
- oErr  out  1  one-cycle pulse when an out-of-range host write is dropped.
REQ-003 The block SHALL have one clock (iClk); reset iRst SHALL be asynchronous and active-high.

Function
REQ-004 A host write SHALL be accepted into the FIFO on any cycle where iWrValid and oWrReady are both high.
REQ-005 oWrReady SHALL be low when the FIFO is full.
REQ-006 A push to a full FIFO SHALL be impossible; a push and a pop in the same cycle SHALL keep the occupancy unchanged.
REQ-007 A display slot SHALL occur on the cycles where iCountH<WIDTH, iCountV<HEIGHT and iCountH[SCALE_SH-1:0]==0.
REQ-008 In a display slot, the registered memory port SHALL issue a read: oMemAddr=(iCountV>>SCALE_SH)*(WIDTH>>SCALE_SH)+(iCountH>>SCALE_SH), oMemWe=0.
REQ-009 On every non-display-slot cycle with the FIFO non-empty, the head entry SHALL be popped and issued as a write: oMemWe=1, with oMemAddr and oMemWData taken from the entry.
REQ-010 Display slots SHALL always have priority over host writes.
REQ-011 Host writes SHALL get at least 3 of every 4 cycles in active video and every cycle in blanking.
REQ-012 A popped entry with an address >= FB_W*FB_H SHALL be discarded: oMemWe=0 and oErr pulsed for 1 cycle.
REQ-013 Pixel latency SHALL be 3 cycles:
- counts sampled at cycle t;
- oMemAddr valid at t+1;
- iMemRData valid at t+2;
- RGB registered at t+3.
REQ-014 The RGB outputs SHALL hold the fetched pixel for all 2^SCALE_SH clocks of that framebuffer column.
REQ-015 The RGB outputs SHALL be 0 for any count outside the active area, aligned with the same 3-cycle latency.
REQ-016 The arbitration state SHALL be {IDLE, DISP_RD, HOST_WR}, registered each cycle, with oMemWe=1 only in HOST_WR.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the FIFO SHALL use an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-018 The framebuffer address multiply SHALL be computed at ADDR_W bits; the product of the maximum coordinates SHALL fit without truncation.

Reset
REQ-019 While iRst is high, the block SHALL clear the FIFO and hold:
- state=IDLE;
- oMemWe=0, oMemAddr=0, oMemWData=0;
- RGB=0, oErr=0;
- oWrReady=0.
REQ-020 oWrReady SHALL go high on the first clock after iRst deasserts.
REQ-021 An assertion of iRst during a pending or in-flight write SHALL abort it; no oMemWe pulse SHALL follow reset assertion.

Structure
REQ-022 The RGB444 pixel width (12), the state encoding, and the FB_W/FB_H derivation SHALL live in the shared package vga_pkg.
REQ-023 The host write FIFO SHALL be a separate sub-module, vga_wr_fifo (sync FIFO with valid/ready push and pop/empty).

Verification
REQ-024 Blanking line (iCountV=490), 4 back-to-back writes -> 4 consecutive oMemWe pulses, addresses and data in order, oWrReady never low.
REQ-025 Active video, iCountH=0..7 on line V=8 -> reads at oMemAddr=320 and 321 on the cycles after H=0 and H=4; host writes occupy only the other cycles.
REQ-026 iMemRData=12'hF0A for address 320 -> RGB=F,0,A for exactly 4 cycles, starting 3 cycles after H=0.
REQ-027 Six writes pushed while iWrValid is held during active video -> oWrReady low when occupancy reaches 4; no write lost; all 6 reach memory.
REQ-028 Host write to address 19200 -> oErr pulses once and no oMemWe is issued for it.
REQ-029 iRst asserted with 3 FIFO entries pending -> oMemWe=0 immediately; after release, the FIFO is empty and oWrReady=1 one clock later.
